bird_motion: RTL and testbench
==============================

// Module: bird_motion
// PURPOSE
//  Vertical physics for the bird; sits directly downstream of the key edge detector.
//  Consumes its one-cycle flap pulse, applies a fixed upward jump per flap and a
//  periodic one-row gravity fall, and detects ground/pipe death. Drives bird row
//  (binary + one-hot) to the LED-array renderer and the game-state logic.
// PARAMETERS
//  ROWS         16          rows in display column; row 0 = top, ROWS-1 = ground
//  START_ROW    8           bird row after reset / while idle
//  FLAP_HEIGHT  2           rows gained per flap pulse
//  FALL_TICKS   25_000_000  clock cycles per gravity step (bench uses 4)
//  ROW_W        $clog2(ROWS) width of row index (derived, localparam)
// PORTS
//  Clock        in   1       system clock; all logic on posedge
//  Reset        in   1       synchronous, active-high
//  flap         in   1       one-cycle pulse, one per key press
//  hit          in   1       pipe collision from obstacle logic, level, sampled each cycle
//  bird_row     out  ROW_W   current bird row, registered
//  bird_onehot  out  ROWS    one-hot of bird_row (bit bird_row set), registered
//  flying       out  1       1 while state == B_FLY
//  dead         out  1       1 while state == B_DEAD
// BEHAVIOUR
//  - Reset (sync, highest priority, any state): state=B_IDLE, bird_row=START_ROW,
//    bird_onehot=1<<START_ROW, tick counter=0, flying=0, dead=0. Takes effect next edge.
//  - States: B_IDLE -> B_FLY on flap; B_FLY -> B_DEAD on hit or ground;
//    B_DEAD -> B_IDLE only via Reset.
//  - B_IDLE: row held, tick counter held at 0, hit ignored. Flap: same edge goes to
//    B_FLY and applies the jump.
//  - Jump: row_next = (row >= FLAP_HEIGHT) ? row-FLAP_HEIGHT : 0 (saturates at top,
//    no wrap). The tick counter clears to 0 on every applied flap.
//  - Gravity: in B_FLY the counter counts 0..FALL_TICKS-1 and wraps. At terminal
//    count, row_next = row+1.
//  - Ground: when a gravity step makes row_next == ROWS-1, that same edge sets
//    state=B_DEAD and row=ROWS-1. Row never exceeds ROWS-1.
//  - Priority in B_FLY, same cycle: Reset > hit > flap > gravity tick.
//    hit: -> B_DEAD, row unchanged.
//    flap + terminal tick: jump only, counter cleared, no fall that cycle.
//  - B_DEAD: row, onehot and counter frozen; flap and hit ignored.
//  - Latency: flap/tick/hit to outputs = 1 clock. All outputs come from flops; no
//    combinational input-to-output path.
//  - flying/dead decoded from the registered state; never both 1.
//  - Arithmetic: compare before subtract (no underflow). The counter is
//    $clog2(FALL_TICKS) bits wide, min 1.
// STRUCTURE
//  - Package flappy_pkg: typedef enum logic [1:0] {B_IDLE,B_FLY,B_DEAD} bird_state_t;
//    shared localparams ROWS, START_ROW for renderer/obstacle blocks.
//  - Sub-module tick_gen (params FALL_TICKS; ports Clock, Reset, en, clr, tick):
//    counter with synchronous clear, one-cycle tick at terminal count.
//  - bird_motion holds the FSM, row register and one-hot decode register.
// TESTING (ROWS=16, START_ROW=8, FLAP_HEIGHT=2, FALL_TICKS=4)
//  1. Reset 2 cycles -> bird_row=8, bird_onehot=16'h0100, flying=0, dead=0.
//     Then 20 idle cycles with no flap/hit -> unchanged.
//  2. Flap pulse in idle -> next edge row=6, flying=1. No input -> row 7 four
//     cycles later, 8 after eight.
//  3. Flaps to row 1 then one more flap -> row 0. Flap at row 0 -> stays 0.
//     Check onehot=16'h0001.
//  4. Free fall from row 8 -> row 15 after 28 cycles; dead=1, flying=0 on the same
//     edge. Later flaps/hit leave row=15.
//  5. Flap coincident with terminal tick at row 10 -> row 8. Next fall exactly
//     4 cycles later.
//  6. hit+flap same cycle at row 5 -> dead=1, row stays 5. Separately, Reset
//     mid-B_FLY at row 3 -> next edge row=8, state idle, counter 0.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy game blocks (bird motion, renderer, obstacles).
// Holds the bird FSM state type, the display geometry and a counter-width helper.
package flappy_pkg;

    typedef enum logic [1:0] {
        B_IDLE = 2'd0,
        B_FLY  = 2'd1,
        B_DEAD = 2'd2
    } bird_state_t;

    localparam int ROWS        = 16;
    localparam int START_ROW   = 8;
    localparam int FLAP_HEIGHT = 2;
    localparam int FALL_TICKS  = 25_000_000;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bird_motion_tick_gen.sv
// Gravity timebase: counts 0..FALL_TICKS-1 while enabled and pulses tick on the terminal count.
// Synchronous clear wins over enable; count is frozen while en is low.
module tick_gen #(
    parameter int FALL_TICKS = 25_000_000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    import flappy_pkg::*;

    localparam int              CW   = cnt_width(FALL_TICKS);
    localparam logic [CW-1:0]   TERM = CW'(FALL_TICKS - 1);

    logic [CW-1:0] count;

    always_ff @(posedge Clock) begin
        if (Reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == TERM) ? '0 : count + CW'(1);
        end
    end

    assign tick = en && (count == TERM);

endmodule

// File: rtl/bird_motion.sv
// Bird vertical physics: flap jumps up, periodic gravity falls one row, ground or pipe hit kills.
// All outputs registered; one clock from flap/hit/tick to bird_row, bird_onehot, flying, dead.
module bird_motion #(
    parameter int ROWS        = flappy_pkg::ROWS,
    parameter int START_ROW   = flappy_pkg::START_ROW,
    parameter int FLAP_HEIGHT = flappy_pkg::FLAP_HEIGHT,
    parameter int FALL_TICKS  = flappy_pkg::FALL_TICKS
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     flap,
    input  logic                     hit,
    output logic [$clog2(ROWS)-1:0]  bird_row,
    output logic [ROWS-1:0]          bird_onehot,
    output logic                     flying,
    output logic                     dead
);
    import flappy_pkg::*;

    localparam int                ROW_W     = $clog2(ROWS);
    localparam logic [ROW_W-1:0]  GROUND    = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0]  FLAP_ROWS = ROW_W'(FLAP_HEIGHT);
    localparam logic [ROW_W-1:0]  START     = ROW_W'(START_ROW);

    bird_state_t       state;
    bird_state_t       state_next;
    logic [ROW_W-1:0]  row_next;
    logic              flap_ok;
    logic              tick;
    logic              tick_en;
    logic              tick_clr;

    // Compare before subtracting so the jump saturates at the top row.
    function automatic logic [ROW_W-1:0] jump(input logic [ROW_W-1:0] row);
        return (row >= FLAP_ROWS) ? row - FLAP_ROWS : '0;
    endfunction

    function automatic logic [ROWS-1:0] decode(input logic [ROW_W-1:0] row);
        logic [ROWS-1:0] oh;
        oh      = '0;
        oh[row] = 1'b1;
        return oh;
    endfunction

    always_comb begin
        state_next = state;
        row_next   = bird_row;
        flap_ok    = 1'b0;
        case (state)
            B_IDLE: begin
                if (flap) begin
                    state_next = B_FLY;
                    row_next   = jump(bird_row);
                    flap_ok    = 1'b1;
                end
            end
            B_FLY: begin
                if (hit) begin
                    state_next = B_DEAD;
                end else if (flap) begin
                    row_next = jump(bird_row);
                    flap_ok  = 1'b1;
                end else if (tick) begin
                    row_next = (bird_row < GROUND) ? bird_row + ROW_W'(1) : GROUND;
                    if (row_next == GROUND) begin
                        state_next = B_DEAD;
                    end
                end
            end
            B_DEAD: begin
                state_next = B_DEAD;
            end
            default: begin
                state_next = B_IDLE;
                row_next   = START;
            end
        endcase
    end

    // Gravity only runs while airborne; a flap restarts the fall interval.
    assign tick_en  = (state == B_FLY) && !hit;
    assign tick_clr = (state == B_IDLE) || flap_ok;

    tick_gen #(
        .FALL_TICKS (FALL_TICKS)
    ) u_tick_gen (
        .Clock (Clock),
        .Reset (Reset),
        .en    (tick_en),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= B_IDLE;
            bird_row    <= START;
            bird_onehot <= decode(START);
        end else begin
            state       <= state_next;
            bird_row    <= row_next;
            bird_onehot <= decode(row_next);
        end
    end

    assign flying = (state == B_FLY);
    assign dead   = (state == B_DEAD);

endmodule

// File: tb/tb_bird_motion.sv
// Randomised and directed bench for bird_motion against a cycle-level behavioural model.
module tb_bird_motion;

    localparam int ROWS  = 16;
    localparam int START = 8;
    localparam int JUMP  = 2;
    localparam int FT    = 4;

    logic        Clock;
    logic        Reset;
    logic        flap;
    logic        hit;
    logic [3:0]  bird_row;
    logic [15:0] bird_onehot;
    logic        flying;
    logic        dead;

    int checks = 0;
    int errors = 0;

    // Model: 0 idle, 1 flying, 2 dead; m_cnt = cycles since the fall interval restarted.
    int m_state = 0;
    int m_row   = START;
    int m_cnt   = 0;
    bit m_vld   = 0;

    bird_motion #(
        .ROWS        (ROWS),
        .START_ROW   (START),
        .FLAP_HEIGHT (JUMP),
        .FALL_TICKS  (FT)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .flap        (flap),
        .hit         (hit),
        .bird_row    (bird_row),
        .bird_onehot (bird_onehot),
        .flying      (flying),
        .dead        (dead)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial forever begin
        @(posedge Clock);
        if (Reset) begin
            m_state = 0;
            m_row   = START;
            m_cnt   = 0;
            m_vld   = 1;
        end else if (m_state == 0) begin
            if (flap) begin
                m_state = 1;
                m_row   = (m_row >= JUMP) ? m_row - JUMP : 0;
                m_cnt   = 0;
            end
        end else if (m_state == 1) begin
            if (hit) begin
                m_state = 2;
            end else if (flap) begin
                m_row = (m_row >= JUMP) ? m_row - JUMP : 0;
                m_cnt = 0;
            end else if (m_cnt == FT - 1) begin
                m_cnt = 0;
                m_row = m_row + 1;
                if (m_row == ROWS - 1) m_state = 2;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    end

    initial forever begin
        @(negedge Clock);
        if (m_vld) begin
            logic [15:0] exp_oh;
            exp_oh = 16'd1 << m_row;
            checks++;
            if (int'(bird_row) != m_row || bird_onehot != exp_oh ||
                flying != (m_state == 1) || dead != (m_state == 2)) begin
                errors++;
                $display("FAIL model_cmp t=%0t row=%0d oh=%h fly=%0b dead=%0b required row=%0d oh=%h fly=%0b dead=%0b",
                         $time, bird_row, bird_onehot, flying, dead,
                         m_row, exp_oh, m_state == 1, m_state == 2);
            end
        end
    end

    task automatic cyc(input bit f, input bit h, input bit r);
        flap  = f;
        hit   = h;
        Reset = r;
        @(posedge Clock);
        @(negedge Clock);
        flap  = 1'b0;
        hit   = 1'b0;
        Reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    initial begin
        flap  = 1'b0;
        hit   = 1'b0;
        Reset = 1'b1;

        // Reset and idle hold
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        chk("reset_row", int'(bird_row), 8);
        chk("reset_onehot", int'(bird_onehot), 'h0100);
        chk("reset_flying", int'(flying), 0);
        chk("reset_dead", int'(dead), 0);
        idle(20);
        chk("idle_row", int'(bird_row), 8);
        chk("idle_flying", int'(flying), 0);

        // First flap and gravity cadence
        cyc(1, 0, 0);
        chk("flap_row", int'(bird_row), 6);
        chk("flap_flying", int'(flying), 1);
        idle(3);
        chk("pre_fall_row", int'(bird_row), 6);
        idle(1);
        chk("fall1_row", int'(bird_row), 7);
        idle(4);
        chk("fall2_row", int'(bird_row), 8);

        // Climb to the top and saturate
        idle(4);
        chk("row9", int'(bird_row), 9);
        repeat (4) cyc(1, 0, 0);
        chk("climb_row1", int'(bird_row), 1);
        cyc(1, 0, 0);
        chk("top_row0", int'(bird_row), 0);
        cyc(1, 0, 0);
        chk("sat_row0", int'(bird_row), 0);
        chk("sat_onehot", int'(bird_onehot), 'h0001);

        // Free fall into the ground
        idle(32);
        chk("fall_to_8", int'(bird_row), 8);
        idle(27);
        chk("row14", int'(bird_row), 14);
        chk("row14_flying", int'(flying), 1);
        idle(1);
        chk("ground_row", int'(bird_row), 15);
        chk("ground_dead", int'(dead), 1);
        chk("ground_flying", int'(flying), 0);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        cyc(1, 1, 0);
        idle(8);
        chk("dead_frozen_row", int'(bird_row), 15);
        chk("dead_frozen_oh", int'(bird_onehot), 'h8000);

        // Flap coincident with terminal tick
        cyc(0, 0, 1);
        chk("rst_from_dead", int'(dead), 0);
        cyc(1, 0, 0);
        idle(16);
        chk("row10", int'(bird_row), 10);
        idle(3);
        cyc(1, 0, 0);
        chk("flap_on_tick", int'(bird_row), 8);
        idle(3);
        chk("no_early_fall", int'(bird_row), 8);
        idle(1);
        chk("fall_after_flap", int'(bird_row), 9);

        // Hit beats flap
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        idle(4);
        cyc(1, 0, 0);
        chk("row5", int'(bird_row), 5);
        cyc(1, 1, 0);
        chk("hit_dead", int'(dead), 1);
        chk("hit_row", int'(bird_row), 5);
        idle(10);
        chk("hit_frozen", int'(bird_row), 5);

        // Reset mid-flight
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        idle(4);
        cyc(1, 0, 0);
        chk("row3", int'(bird_row), 3);
        cyc(0, 0, 1);
        chk("midrst_row", int'(bird_row), 8);
        chk("midrst_flying", int'(flying), 0);
        idle(10);
        chk("midrst_idle_row", int'(bird_row), 8);

        // Random traffic, checked every cycle by the model comparator
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 4) == 0, $urandom_range(0, 59) == 0,
                $urandom_range(0, 149) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
